// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared size-code encoding, FSM states and helpers for the LSU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int c_NB_WIDTH = 3;

    typedef enum logic [c_NB_WIDTH-1:0] {
        NB_B  = 3'd0,
        NB_BU = 3'd1,
        NB_H  = 3'd2,
        NB_HU = 3'd3,
        NB_W  = 3'd4
    } num_byte_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Codes 5-7 are unused by the control unit and alias to a word access.
    function automatic num_byte_e nb_decode(input logic [c_NB_WIDTH-1:0] code);
        return (code > 3'd4) ? NB_W : num_byte_e'(code);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Selects the addressed lane of a read word and sign/zero-extends it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  num_byte_e   i_size,
    output logic [31:0] o_data
);

    logic [31:0] w_lane;

    assign w_lane = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_lane;
        case (i_size)
            NB_B:    o_data = {{24{w_lane[7]}}, w_lane[7:0]};
            NB_BU:   o_data = {24'd0, w_lane[7:0]};
            NB_H:    o_data = {{16{w_lane[15]}}, w_lane[15:0]};
            NB_HU:   o_data = {16'd0, w_lane[15:0]};
            default: o_data = w_lane;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
// ============================================================================
//  Module   : lsu_dmem_ctrl
//  Purpose  : Multi-cycle load/store unit driving a req/gnt/rvalid data bus.
//             Define LSU_ALIGN_CHECK_EN to trap misaligned h/w accesses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_wren,
    input  logic [2:0]        num_byte,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              done,
    output logic              misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    num_byte_e         r_size;
    logic [1:0]        r_off;
    logic              r_misalign;
    logic [31:0]       r_ld_data;

    logic              w_op;
    num_byte_e         w_size;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misalign;
    logic [31:0]       w_ld_ext;

    assign w_op   = mem_read | mem_wren;
    assign w_size = nb_decode(num_byte);

    // Lane decode; w_off is the offset actually used for load extraction,
    // with unaligned low bits of h/w accesses dropped.
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = st_data;
        case (w_size)
            NB_B, NB_BU: begin
                w_off   = addr[1:0];
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{st_data[7:0]}};
            end
            NB_H, NB_HU: begin
                w_off   = {addr[1], 1'b0};
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                w_be    = 4'b1111;
                w_wdata = st_data;
            end
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = (((w_size == NB_H) || (w_size == NB_HU)) && addr[0]) ||
                        ((w_size == NB_W) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    lsu_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_off),
        .i_size   (r_size),
        .o_data   (w_ld_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_op)        w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem_gnt)    w_state_nxt = r_we ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem_rvalid) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'd0;
            r_size     <= NB_B;
            r_off      <= 2'b00;
            r_misalign <= 1'b0;
            r_ld_data  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_op) begin
                        r_req      <= ~w_misalign;
                        r_we       <= mem_wren;
                        r_addr     <= {addr[ADDR_W-1:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_size     <= w_size;
                        r_off      <= w_off;
                        r_misalign <= w_misalign;
                        if (w_misalign) begin
                            r_ld_data <= 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        r_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_ld_data <= w_ld_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = w_op & (r_state != ST_DONE) & ~rst;
    assign done       = (r_state == ST_DONE);
    assign misalign   = (r_state == ST_DONE) & r_misalign;
    assign ld_data    = r_ld_data;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule

`default_nettype wire
